vl53l0x_i2c_responder: RTL

//  I2C target (responder) emulating the VL53L0X register interface at 7'h29: the far end of the sensor bus

---
 rtl/vl53l0x_i2c_responder_pkg.sv | 46 ++++
 rtl/vl53l0x_i2c_responder_bus_sync.sv | 45 ++++
 rtl/vl53l0x_i2c_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vl53l0x_i2c_responder_pkg.sv
// Shared constants, FSM encoding and the read-map decode for the VL53L0X
// register-interface responder.
package vl53l0x_i2c_responder_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT  = 7'h29;
    localparam logic [7:0] DEVICE_ID_DEFAULT = 8'hEE;

    localparam logic [7:0] REG_SYSRANGE_START   = 8'h00;
    localparam logic [7:0] REG_INT_CLEAR        = 8'h0B;
    localparam logic [7:0] REG_RESULT_INT_STAT  = 8'h13;
    localparam logic [7:0] REG_RANGE_HI         = 8'h1E;
    localparam logic [7:0] REG_RANGE_LO         = 8'h1F;
    localparam logic [7:0] REG_MODEL_ID         = 8'hC0;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RACK      = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    // Read map: only the identification, interrupt status and range
    // registers return data; everything else reads as zero.
    function automatic logic [7:0] read_mux(input logic [7:0]  ptr,
                                            input logic [15:0] rng,
                                            input logic        vld,
                                            input logic [7:0]  dev_id);
        logic [7:0] val;
        val = 8'h00;
        case (ptr)
            REG_MODEL_ID:        val = dev_id;
            REG_RESULT_INT_STAT: val = {5'b0, (vld ? 3'b100 : 3'b000)};
            REG_RANGE_HI:        val = rng[15:8];
            REG_RANGE_LO:        val = rng[7:0];
            default:             val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vl53l0x_i2c_responder_bus_sync.sv
// Two-flop synchroniser for the raw I2C pad inputs plus SCL edge and
// START/STOP condition pulses, all derived from synchronised levels.
module vl53l0x_i2c_responder_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta, scl_s, scl_d;
    logic sda_meta, sda_s, sda_d;

    // Synchronise both lines and keep one extra stage for edge detection;
    // reset to the idle-bus level so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            scl_d    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_s    <= scl_meta;
            scl_d    <= scl_s;
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
            sda_d    <= sda_s;
        end
    end

    assign sda       = sda_s;
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SDA may only move while SCL is high to signal START/STOP.
    assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/vl53l0x_i2c_responder.sv
// I2C target emulating the VL53L0X register interface. Register writes are
// not stored; they are forwarded to the fabric as single-cycle strobes.
// Handshake: wr_valid, start_meas and int_clear are unqualified one-cycle
// pulses (no ready); wr_addr/wr_data are meaningful in the cycle wr_valid is 1.
module vl53l0x_i2c_responder
    import vl53l0x_i2c_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter logic [7:0] DEVICE_ID = DEVICE_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] range_mm,
    input  logic        range_valid,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        start_meas,
    output logic        int_clear,
    output logic        busy,
    output logic [3:0]  state_dbg
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    vl53l0x_i2c_responder_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  reg_ptr_q, reg_ptr_d;
    logic [15:0] snap_range_q, snap_range_d;
    logic        snap_valid_q, snap_valid_d;
    logic        rw_q, rw_d;
    logic        sda_oe_d, busy_d;
    logic        wr_valid_d, start_meas_d, int_clear_d;
    logic [7:0]  wr_addr_d, wr_data_d;

    logic [7:0]  rx_byte;
    logic [7:0]  ptr_inc;
    logic [7:0]  rd_first;
    logic [7:0]  rd_next;

    // Byte completed by the bit being sampled this cycle.
    assign rx_byte  = {shift_q[6:0], sda_s};
    assign ptr_inc  = reg_ptr_q + 8'd1;
    // First byte of a read comes from the live inputs (snapshot is being
    // captured in the same cycle); later bytes come from the snapshot.
    assign rd_first = read_mux(reg_ptr_q, range_mm, range_valid, DEVICE_ID);
    assign rd_next  = read_mux(ptr_inc, snap_range_q, snap_valid_q, DEVICE_ID);
    assign state_dbg = state_q;

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            tx_q         <= 8'h00;
            reg_ptr_q    <= 8'h00;
            snap_range_q <= 16'h0000;
            snap_valid_q <= 1'b0;
            rw_q         <= 1'b0;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            wr_valid     <= 1'b0;
            wr_addr      <= 8'h00;
            wr_data      <= 8'h00;
            start_meas   <= 1'b0;
            int_clear    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            reg_ptr_q    <= reg_ptr_d;
            snap_range_q <= snap_range_d;
            snap_valid_q <= snap_valid_d;
            rw_q         <= rw_d;
            sda_oe       <= sda_oe_d;
            busy         <= busy_d;
            wr_valid     <= wr_valid_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            start_meas   <= start_meas_d;
            int_clear    <= int_clear_d;
        end
    end

    // Next-state and output decode. START/STOP override every state. In the
    // *_ACK states sda_oe doubles as the phase flag: the first SCL fall
    // starts driving the ACK, the second ends the ACK slot.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        reg_ptr_d    = reg_ptr_q;
        snap_range_d = snap_range_q;
        snap_valid_d = snap_valid_q;
        rw_d         = rw_q;
        sda_oe_d     = sda_oe;
        busy_d       = busy;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        start_meas_d = 1'b0;
        int_clear_d  = 1'b0;

        if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            snap_range_d = range_mm;
                            snap_valid_d = range_valid;
                            tx_d         = rd_first;
                            sda_oe_d     = ~rd_first[7];
                            state_d      = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = REG;
                        end
                    end
                end
                REG: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        reg_ptr_d = rx_byte;
                        state_d   = REG_ACK;
                    end
                end
                REG_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = WDATA;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        wr_valid_d   = 1'b1;
                        wr_addr_d    = reg_ptr_q;
                        wr_data_d    = rx_byte;
                        start_meas_d = (reg_ptr_q == REG_SYSRANGE_START) && (rx_byte == 8'h01);
                        int_clear_d  = (reg_ptr_q == REG_INT_CLEAR);
                        state_d      = WDATA_ACK;
                    end
                end
                WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        reg_ptr_d = ptr_inc;
                        state_d   = WDATA;
                    end
                end
                RDATA: begin
                    // bit_cnt counts bits already presented on SCL rises;
                    // each fall drives the next bit, MSB first.
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
                    end
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            state_d   = RACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RACK: begin
                    // bit_cnt phases: 0 release SDA, 1 sample initiator ACK,
                    // 2 present next byte.
                    if (scl_fall && bit_cnt_q == 3'd0) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd1;
                    end else if (scl_rise && bit_cnt_q == 3'd1) begin
                        if (sda_s) state_d = IGNORE;
                        else       bit_cnt_d = 3'd2;
                    end else if (scl_fall && bit_cnt_q == 3'd2) begin
                        reg_ptr_d = ptr_inc;
                        tx_d      = rd_next;
                        sda_oe_d  = ~rd_next[7];
                        bit_cnt_d = 3'd0;
                        state_d   = RDATA;
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
